cnt_bcd_multi: RTL and testbench

CNT_BCD_MULTI -- requirements
Module: cnt_bcd_multi

---
 rtl/cnt_bcd_multi_pkg.sv | 14 +
 rtl/cnt_bcd_multi_digit.sv | 59 +++++
 rtl/cnt_bcd_multi.sv | 103 ++++++++++
 tb/tb_cnt_bcd_multi.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cnt_bcd_multi_pkg.sv
// Shared BCD constants and a nibble validity helper for the multi-digit
// BCD counter and its per-digit building block.
package cnt_bcd_multi_pkg;

    localparam int          DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [3:0]  BCD_MIN = 4'd0;

    // True when a nibble is a legal BCD digit (0..9).
    function automatic logic bcd_valid(input logic [DIGIT_W-1:0] nib);
        return (nib <= BCD_MAX);
    endfunction

endpackage

// File: rtl/cnt_bcd_multi_digit.sv
// bcd_digit: one decade of the cascaded BCD counter.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (loads INIT)
//   cnt_en      count this digit on the next edge (carry/borrow already applied)
//   up          1 = increment, 0 = decrement
//   load        parallel load of load_val (invalid nibbles load as 0)
//   clr         synchronous clear, highest priority
//   load_val    value to load
//   value       current digit value, always 0..9
//   is_9, is_0  status used by the top to build the carry/borrow chain
module bcd_digit
    import cnt_bcd_multi_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] INIT = BCD_MIN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cnt_en,
    input  logic               up,
    input  logic               load,
    input  logic               clr,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] value,
    output logic               is_9,
    output logic               is_0
);

    logic [DIGIT_W-1:0] value_reg;
    logic [DIGIT_W-1:0] value_next;

    assign value = value_reg;
    assign is_9  = (value_reg == BCD_MAX);
    assign is_0  = (value_reg == BCD_MIN);

    always_comb begin
        value_next = value_reg;
        if (clr) begin
            value_next = BCD_MIN;
        end else if (load) begin
            // Out-of-range nibbles are squashed to 0 so the digit never leaves 0..9.
            value_next = bcd_valid(load_val) ? load_val : BCD_MIN;
        end else if (cnt_en) begin
            if (up) begin
                value_next = is_9 ? BCD_MIN : value_reg + 4'd1;
            end else begin
                value_next = is_0 ? BCD_MAX : value_reg - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_reg <= INIT;
        end else begin
            value_reg <= value_next;
        end
    end

endmodule

// File: rtl/cnt_bcd_multi.sv
// cnt_bcd_multi: DIGITS-decade up/down BCD counter with load, clear,
// cascade carry and sticky wrap / invalid-load flags.
// Ports:
//   CLK   rising-edge clock
//   RST   asynchronous active-high reset (DOUT=INIT, OVF=ERR=0)
//   EN    count/load enable
//   LOAD  active-low synchronous parallel load (needs EN)
//   CLR   synchronous clear of count and flags, independent of EN
//   UP    1 = count up, 0 = count down
//   DATA  packed BCD load value, digit 0 in [3:0]
//   DOUT  packed BCD count
//   COUT  combinational terminal count: high in the cycle before a full wrap
//   OVF   sticky full-wrap flag
//   ERR   sticky invalid-load flag
module cnt_bcd_multi
    import cnt_bcd_multi_pkg::*;
#(
    parameter int                       DIGITS = 4,
    parameter logic [4*DIGITS-1:0]      INIT   = '0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN,
    input  logic                    LOAD,
    input  logic                    CLR,
    input  logic                    UP,
    input  logic [4*DIGITS-1:0]     DATA,
    output logic [4*DIGITS-1:0]     DOUT,
    output logic                    COUT,
    output logic                    OVF,
    output logic                    ERR
);

    logic              load_ev;
    logic              count_ev;
    logic [DIGITS:0]   chain;        // chain[k]: all digits below k at terminal value
    logic [DIGITS-1:0] is_9;
    logic [DIGITS-1:0] is_0;
    logic [DIGITS-1:0] nibble_bad;
    logic              ovf_reg, ovf_next;
    logic              err_reg, err_next;

    assign load_ev  = EN & ~LOAD & ~CLR;
    assign count_ev = EN &  LOAD & ~CLR;
    assign chain[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_digit
            // Ripple carry (up) or borrow (down) to the next decade.
            assign chain[gi+1]    = chain[gi] & (UP ? is_9[gi] : is_0[gi]);
            assign nibble_bad[gi] = ~bcd_valid(DATA[DIGIT_W*gi +: DIGIT_W]);

            bcd_digit #(
                .INIT     (INIT[DIGIT_W*gi +: DIGIT_W])
            ) u_digit (
                .clk      (CLK),
                .rst      (RST),
                .cnt_en   (count_ev & chain[gi]),
                .up       (UP),
                .load     (load_ev),
                .clr      (CLR),
                .load_val (DATA[DIGIT_W*gi +: DIGIT_W]),
                .value    (DOUT[DIGIT_W*gi +: DIGIT_W]),
                .is_9     (is_9[gi]),
                .is_0     (is_0[gi])
            );
        end
    endgenerate

    // Every digit at its terminal value while counting means the next edge wraps.
    assign COUT = count_ev & chain[DIGITS];
    assign OVF  = ovf_reg;
    assign ERR  = err_reg;

    always_comb begin
        ovf_next = ovf_reg;
        err_next = err_reg;
        if (CLR) begin
            ovf_next = 1'b0;
            err_next = 1'b0;
        end else if (load_ev) begin
            if (|nibble_bad) begin
                err_next = 1'b1;
            end else begin
                ovf_next = 1'b0;
            end
        end else if (COUT) begin
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
            err_reg <= err_next;
        end
    end

endmodule

// File: tb/tb_cnt_bcd_multi.sv
// Scoreboard bench for cnt_bcd_multi: a 4-digit instance (INIT=0) and a
// 2-digit instance (INIT=0x42). Each stimulus step pushes the values the
// DUT must show at the following falling edge; monitors pop and compare.
module tb_cnt_bcd_multi;

    typedef struct {
        logic [15:0] dout;
        logic        cout;
        logic        ovf;
        logic        err;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst1, en1, load1, clr1, up1;
    logic [15:0] data1;
    logic [15:0] dout1;
    logic        cout1, ovf1, err1;
    logic        rst2, en2, load2, clr2, up2;
    logic [7:0]  data2;
    logic [7:0]  dout2;
    logic        cout2, ovf2, err2;

    exp_t q1[$];
    exp_t q2[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    cnt_bcd_multi #(.DIGITS(4), .INIT(16'h0000)) dut1 (
        .CLK(clk), .RST(rst1), .EN(en1), .LOAD(load1), .CLR(clr1), .UP(up1),
        .DATA(data1), .DOUT(dout1), .COUT(cout1), .OVF(ovf1), .ERR(err1)
    );

    cnt_bcd_multi #(.DIGITS(2), .INIT(8'h42)) dut2 (
        .CLK(clk), .RST(rst2), .EN(en2), .LOAD(load2), .CLR(clr2), .UP(up2),
        .DATA(data2), .DOUT(dout2), .COUT(cout2), .OVF(ovf2), .ERR(err2)
    );

    task automatic check(input string name, input string field,
                         input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitors: sample away from the rising edge.
    always @(negedge clk) begin
        if (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            check(e.name, "dout", dout1, e.dout);
            check(e.name, "cout", {15'd0, cout1}, {15'd0, e.cout});
            check(e.name, "ovf",  {15'd0, ovf1},  {15'd0, e.ovf});
            check(e.name, "err",  {15'd0, err1},  {15'd0, e.err});
            $display("dut1 %-12s dout=%h cout=%b ovf=%b err=%b", e.name, dout1, cout1, ovf1, err1);
        end
        if (q2.size() > 0) begin
            exp_t e;
            e = q2.pop_front();
            check(e.name, "dout", {8'd0, dout2}, e.dout);
            check(e.name, "cout", {15'd0, cout2}, {15'd0, e.cout});
            check(e.name, "ovf",  {15'd0, ovf2},  {15'd0, e.ovf});
            check(e.name, "err",  {15'd0, err2},  {15'd0, e.err});
            $display("dut2 %-12s dout=%h cout=%b ovf=%b err=%b", e.name, dout2, cout2, ovf2, err2);
        end
    end

    // Drive one cycle of inputs just after the rising edge; the expectation
    // describes DOUT/flags from the previous edge and COUT for these inputs.
    task automatic step1(input logic en, input logic load, input logic clr, input logic up,
                         input logic [15:0] data, input logic [15:0] xd, input logic xc,
                         input logic xo, input logic xe, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        en1 = en; load1 = load; clr1 = clr; up1 = up; data1 = data;
        e.dout = xd; e.cout = xc; e.ovf = xo; e.err = xe; e.name = name;
        q1.push_back(e);
    endtask

    task automatic step2(input logic en, input logic load, input logic up,
                         input logic [7:0] data, input logic rst_pulse,
                         input logic [7:0] xd, input logic xc, input logic xo,
                         input string name);
        exp_t e;
        @(posedge clk);
        #1;
        en2 = en; load2 = load; clr2 = 1'b0; up2 = up; data2 = data;
        if (rst_pulse) rst2 = 1'b1;
        e.dout = {8'd0, xd}; e.cout = xc; e.ovf = xo; e.err = 1'b0; e.name = name;
        q2.push_back(e);
        if (rst_pulse) begin
            #5;            // released after the monitor sample, before the next edge
            rst2 = 1'b0;
        end
    endtask

    initial begin
        rst1 = 1'b1; en1 = 1'b0; load1 = 1'b1; clr1 = 1'b0; up1 = 1'b1; data1 = '0;
        rst2 = 1'b1; en2 = 1'b0; load2 = 1'b1; clr2 = 1'b0; up2 = 1'b1; data2 = '0;

        // ---------------- 4-digit instance ----------------
        step1(0,1,0,1,16'h0000, 16'h0000,0,0,0, "reset");
        rst1 = 1'b0;
        // 9998 up through wrap
        step1(1,0,0,1,16'h9998, 16'h0000,0,0,0, "ld9998");
        step1(1,1,0,1,16'h0000, 16'h9998,0,0,0, "up_9998");
        step1(1,1,0,1,16'h0000, 16'h9999,1,0,0, "up_9999");
        step1(0,1,0,1,16'h0000, 16'h0000,0,1,0, "wrap_up");
        // 0001 down through wrap
        step1(1,0,0,0,16'h0001, 16'h0000,0,1,0, "ld0001");
        step1(1,1,0,0,16'h0000, 16'h0001,0,0,0, "dn_0001");
        step1(1,1,0,0,16'h0000, 16'h0000,1,0,0, "dn_0000");
        step1(0,1,0,0,16'h0000, 16'h9999,0,1,0, "wrap_dn");
        // invalid load, then clear
        step1(1,0,0,1,16'h12A4, 16'h9999,0,1,0, "ld12A4");
        step1(0,1,1,1,16'h0000, 16'h1204,0,1,1, "ld_bad");
        step1(0,1,0,1,16'h0000, 16'h0000,0,0,0, "clr");
        // 0199 -> 0200 then hold
        step1(1,0,0,1,16'h0199, 16'h0000,0,0,0, "ld0199");
        step1(1,1,0,1,16'h0000, 16'h0199,0,0,0, "up_0199");
        step1(0,1,0,1,16'h0000, 16'h0200,0,0,0, "inc_0199");
        step1(0,1,0,1,16'h0000, 16'h0200,0,0,0, "hold1");
        step1(0,0,0,1,16'h5555, 16'h0200,0,0,0, "hold2");
        step1(0,1,0,1,16'h0000, 16'h0200,0,0,0, "hold_noload");
        // CLR wins over count and masks COUT
        step1(1,1,1,1,16'h0000, 16'h0200,0,0,0, "clr_cout");
        // direction change with no idle cycle
        step1(1,0,0,1,16'h0005, 16'h0000,0,0,0, "ld0005");
        step1(1,1,0,1,16'h0000, 16'h0005,0,0,0, "up_0005");
        step1(1,1,0,0,16'h0000, 16'h0006,0,0,0, "dn_0006");
        step1(0,1,0,1,16'h0000, 16'h0005,0,0,0, "dir_change");
        // multi-digit borrow
        step1(1,0,0,0,16'h1000, 16'h0005,0,0,0, "ld1000");
        step1(1,1,0,0,16'h0000, 16'h1000,0,0,0, "dn_1000");
        step1(0,1,0,0,16'h0000, 16'h0999,0,0,0, "borrow");

        // ---------------- 2-digit instance ----------------
        step2(0,1,1,8'h00,0, 8'h42,0,0, "reset42");
        rst2 = 1'b0;
        step2(1,0,1,8'h56,0, 8'h42,0,0, "ld56");
        step2(1,1,1,8'h00,0, 8'h56,0,0, "up_56");
        step2(1,1,1,8'h00,1, 8'h42,0,0, "rst_mid");
        step2(0,1,1,8'h00,0, 8'h43,0,0, "resume");
        step2(1,0,1,8'h99,0, 8'h43,0,0, "ld99");
        step2(1,1,1,8'h00,0, 8'h99,1,0, "up_99");
        step2(1,1,1,8'h00,0, 8'h00,0,1, "wrap2");
        step2(1,1,1,8'h00,1, 8'h42,0,0, "rst_ovf");
        step2(0,1,1,8'h00,0, 8'h43,0,0, "resume2");

        repeat (2) @(posedge clk);
        #6;
        if (q1.size() != 0 || q2.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", q1.size(), q2.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
